tile_renderer: RTL and testbench

Pixel pipeline that sits directly downstream of the `xvga` timing generator and the two people BRAMs. It turns `hcount`/`vcount` into a tile address and reads the displayed buffer's BRAM port B. It colours each pixel from the 30-bit tile record and drives the VGA pins with delay-matched syncs. It owns the double-buffer swap handshake, so the game logic only changes buffers at a frame boundary.

---
 rtl/tiny_world_pkg.sv | 36 +++
 rtl/pipe_delay.sv | 26 ++
 rtl/tile_renderer.sv | 134 +++++++++++++
 tb/tb_tile_renderer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_world_pkg.sv
// Shared constants and types for the tiny_world display path: tile geometry,
// tile record layout and the fixed palette.
package tiny_world_pkg;

   localparam int unsigned TILE_SHIFT = 3;
   localparam int unsigned PF_TILES_X = 128;
   localparam int unsigned PF_TILES_Y = 64;
   localparam int unsigned ADDR_W     = 13;
   localparam int unsigned REC_W      = 30;
   localparam int unsigned REC_LO     = 14;

   typedef enum logic [2:0] {
      TILE_PERSON = 3'd0,
      TILE_FOOD   = 3'd1,
      TILE_WATER  = 3'd2
   } tile_type_e;

   // Upper 16 bits of a tile record; bits [13:0] carry nothing the display uses.
   typedef struct packed {
      logic       valid;
      logic [2:0] ttype;
      logic [11:0] rgb;
   } tile_rec_t;

   localparam logic [11:0] COL_BLANK = 12'h000;
   localparam logic [11:0] COL_BAR   = 12'h222;
   localparam logic [11:0] COL_GRID  = 12'h111;
   localparam logic [11:0] COL_GRASS = 12'h030;
   localparam logic [11:0] COL_FLOOD = 12'h04F;
   localparam logic [11:0] COL_FOOD  = 12'h0F0;
   localparam logic [11:0] COL_WATER = 12'h00F;

   // Side-band order: {hsync, vsync, blank, bar, x_zero, y_zero}.
   localparam logic [5:0] SIDE_RST = 6'b111000;

endpackage

// File: rtl/pipe_delay.sv
// N-stage shift register with asynchronous clear to a per-instance value.
module pipe_delay #(
   parameter int unsigned W       = 1,
   parameter int unsigned N       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_stage [N];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < N; i++) r_stage[i] <= RST_VAL;
      end else begin
         r_stage[0] <= i_d;
         for (int unsigned i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_q = r_stage[N-1];

endmodule

// File: rtl/tile_renderer.sv
// Tile-map pixel pipeline: address, BRAM read, colour; owns the frame-boundary
// double-buffer swap and delay-matches syncs/blank to the colour path.
module tile_renderer
   import tiny_world_pkg::*;
#(
   parameter int unsigned BRAM_LAT   = 2,
   parameter int unsigned PLAY_LINES = 512
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        blank_in,
   input  logic        swap_req_in,
   output logic        swap_ack_out,
   output logic        disp_buf_out,
   output logic        frame_start_out,
   output logic [12:0] addr_out,
   input  logic [29:0] data1_in,
   input  logic [29:0] data2_in,
   input  logic        flood_in,
   input  logic        grid_en_in,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs
);

   logic        w_vb_start;
   logic        w_bar;
   logic [5:0]  w_side_d;
   logic [5:0]  w_side_q;
   logic [29:0] w_sel;
   tile_rec_t   w_rec;
   logic [11:0] w_rgb;
   logic        w_unused;

   logic [12:0] r_addr;
   logic        r_disp_buf;
   logic        r_ack;
   logic        r_fs;
   logic        r_flood;
   logic        r_grid;
   logic [11:0] r_rgb;
   logic        r_hs;
   logic        r_vs;

   assign w_vb_start = (vcount_in == 10'd768) && (hcount_in == 11'd0);
   assign w_bar      = vcount_in >= 10'(PLAY_LINES);
   assign w_side_d   = {hsync_in, vsync_in, blank_in, w_bar,
                        hcount_in[2:0] == 3'd0, vcount_in[2:0] == 3'd0};

   // Side-band reaches the colour stage aligned with BRAM data; the final
   // register below supplies the last of the L cycles.
   pipe_delay #(
      .W       (6),
      .N       (BRAM_LAT + 1),
      .RST_VAL (SIDE_RST)
   ) u_side_dly (
      .i_clk   (clk_in),
      .i_rst_n (rst_in),
      .i_d     (w_side_d),
      .o_q     (w_side_q)
   );

   assign w_sel    = r_disp_buf ? data2_in : data1_in;
   assign w_rec    = tile_rec_t'(w_sel[REC_W-1:REC_LO]);
   assign w_unused = &{1'b0, data1_in[REC_LO-1:0], data2_in[REC_LO-1:0]};

   always_comb begin
      w_rgb = COL_GRASS;
      if (w_side_q[3]) begin
         w_rgb = COL_BLANK;
      end else if (w_side_q[2]) begin
         w_rgb = COL_BAR;
      end else if (r_grid && (w_side_q[1] || w_side_q[0])) begin
         w_rgb = COL_GRID;
      end else if (!w_rec.valid) begin
         w_rgb = r_flood ? COL_FLOOD : COL_GRASS;
      end else begin
         case (w_rec.ttype)
            TILE_FOOD:  w_rgb = COL_FOOD;
            TILE_WATER: w_rgb = COL_WATER;
            default:    w_rgb = w_rec.rgb;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_addr     <= '0;
         r_disp_buf <= 1'b0;
         r_ack      <= 1'b0;
         r_fs       <= 1'b0;
         r_flood    <= 1'b0;
         r_grid     <= 1'b0;
      end else begin
         r_addr <= {vcount_in[8:3], hcount_in[9:3]};
         r_fs   <= w_vb_start;
         r_ack  <= w_vb_start && swap_req_in;
         if (w_vb_start) begin
            r_flood <= flood_in;
            r_grid  <= grid_en_in;
            if (swap_req_in) r_disp_buf <= ~r_disp_buf;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_rgb <= '0;
         r_hs  <= 1'b1;
         r_vs  <= 1'b1;
      end else begin
         r_rgb <= w_rgb;
         r_hs  <= w_side_q[5];
         r_vs  <= w_side_q[4];
      end
   end

   assign addr_out        = r_addr;
   assign disp_buf_out    = r_disp_buf;
   assign swap_ack_out    = r_ack;
   assign frame_start_out = r_fs;
   assign vga_r           = r_rgb[11:8];
   assign vga_g           = r_rgb[7:4];
   assign vga_b           = r_rgb[3:0];
   assign vga_hs          = r_hs;
   assign vga_vs          = r_vs;

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer: randomized abbreviated frames, a
// behavioural colour/swap model, and a monitor popping per-cycle expectations.
module tb_tile_renderer;

   localparam int unsigned L = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync, vsync, blank, swap_req, flood, grid;
   logic        swap_ack, disp_buf, frame_start;
   logic [12:0] addr;
   logic [29:0] data1, data2;
   logic [3:0]  vr, vg, vb;
   logic        hs, vs;

   always #5 clk = ~clk;

   tile_renderer #(
      .BRAM_LAT   (2),
      .PLAY_LINES (512)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst_n),
      .hcount_in       (hcount),
      .vcount_in       (vcount),
      .hsync_in        (hsync),
      .vsync_in        (vsync),
      .blank_in        (blank),
      .swap_req_in     (swap_req),
      .swap_ack_out    (swap_ack),
      .disp_buf_out    (disp_buf),
      .frame_start_out (frame_start),
      .addr_out        (addr),
      .data1_in        (data1),
      .data2_in        (data2),
      .flood_in        (flood),
      .grid_en_in      (grid),
      .vga_r           (vr),
      .vga_g           (vg),
      .vga_b           (vb),
      .vga_hs          (hs),
      .vga_vs          (vs)
   );

   // Two-cycle read-latency BRAM port B model.
   logic [29:0] mem1 [8192];
   logic [29:0] mem2 [8192];
   logic [12:0] bram_a;
   always @(posedge clk) begin
      bram_a <= addr;
      data1  <= mem1[bram_a];
      data2  <= mem2[bram_a];
   end

   typedef struct { logic [11:0] rgb; logic hs; logic vs; } pix_t;
   typedef struct { logic [12:0] addr; logic fs; logic ack; logic disp; } ctl_t;

   pix_t pq[$];
   ctl_t cq[$];
   int   checks = 0;
   int   passed = 0;
   bit   mon_en = 0;
   bit   m_disp, m_flood, m_grid;
   bit   want_flood, want_grid;

   function automatic int tile_addr(int h, int v);
      return ((v / 8) % 64) * 128 + (h / 8) % 128;
   endfunction

   function automatic logic [11:0] ref_colour(int h, int v, bit blk);
      logic [29:0] rec;
      int a;
      if (blk) return 12'h000;
      if (v >= 512) return 12'h222;
      if (m_grid && (h % 8 == 0 || v % 8 == 0)) return 12'h111;
      a = tile_addr(h, v);
      rec = m_disp ? mem2[a] : mem1[a];
      if (!rec[29]) return m_flood ? 12'h04F : 12'h030;
      case (rec[28:26])
         3'd1:    return 12'h0F0;
         3'd2:    return 12'h00F;
         default: return rec[25:14];
      endcase
   endfunction

   task automatic drive(input int h, input int v, input bit hsv, input bit vsv, input bit req);
      bit   is_vb;
      pix_t pe;
      ctl_t ce;
      @(negedge clk);
      is_vb    = (h == 0) && (v == 768);
      hcount   = 11'(h);
      vcount   = 10'(v);
      hsync    = hsv;
      vsync    = vsv;
      blank    = (h >= 1024) || (v >= 768);
      swap_req = req;
      flood    = is_vb ? want_flood : 1'($urandom_range(0, 1));
      grid     = is_vb ? want_grid  : 1'($urandom_range(0, 1));
      pe.rgb   = ref_colour(h, v, blank);
      pe.hs    = hsv;
      pe.vs    = vsv;
      if (is_vb) begin
         m_flood = flood;
         m_grid  = grid;
         if (req) m_disp = !m_disp;
      end
      ce.addr = 13'(tile_addr(h, v));
      ce.fs   = is_vb;
      ce.ack  = is_vb && req;
      ce.disp = m_disp;
      pq.push_back(pe);
      cq.push_back(ce);
   endtask

   task automatic pad(input int n);
      repeat (n) drive($urandom_range(1024, 1343), $urandom_range(0, 767),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
   endtask

   // mode: 0 no request, 1 held all frame, 2 rises on vb_start, 3 rises mid-frame
   task automatic frame(input int npix, input int mode);
      bit req;
      for (int i = 0; i < npix; i++) begin
         req = (mode == 1) || (mode == 3 && i >= npix / 2);
         drive($urandom_range(0, 1023), $urandom_range(0, 767),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), req);
      end
      repeat (6) drive($urandom_range(1024, 1343), $urandom_range(0, 767),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       (mode == 1) || (mode == 3));
      drive(0, 768, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mode != 0);
      repeat (6) drive($urandom_range(0, 1343), $urandom_range(769, 805),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mode == 1);
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      #1;
      mon_en = 0;
      rst_n  = 1'b0;
      #1;
      checks++;
      if ({vr, vg, vb, hs, vs} === {12'h000, 1'b1, 1'b1}) passed++;
      else $display("FAIL rst_pins got rgb=%h hs=%b vs=%b need rgb=000 hs=1 vs=1",
                    {vr, vg, vb}, hs, vs);
      checks++;
      if ({addr, disp_buf, swap_ack, frame_start} === 16'h0000) passed++;
      else $display("FAIL rst_ctl got addr=%0d disp=%b ack=%b fs=%b need all 0",
                    addr, disp_buf, swap_ack, frame_start);
      repeat (hold) @(negedge clk);
      pq.delete();
      cq.delete();
      m_disp  = 0;
      m_flood = 0;
      m_grid  = 0;
      repeat (L - 1) pq.push_back('{12'h000, 1'b1, 1'b1});
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1;
   endtask

   pix_t mp;
   ctl_t mc;
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (pq.size() == 0 || cq.size() == 0) begin
            checks++;
            $display("FAIL queue_empty at %0t pix=%0d ctl=%0d need >0", $time, pq.size(), cq.size());
         end else begin
            mp = pq.pop_front();
            mc = cq.pop_front();
            checks++;
            if ({vr, vg, vb, hs, vs} === {mp.rgb, mp.hs, mp.vs}) passed++;
            else $display("FAIL pix at %0t got rgb=%h hs=%b vs=%b need rgb=%h hs=%b vs=%b",
                          $time, {vr, vg, vb}, hs, vs, mp.rgb, mp.hs, mp.vs);
            checks++;
            if ({addr, frame_start, swap_ack, disp_buf} === {mc.addr, mc.fs, mc.ack, mc.disp}) passed++;
            else $display("FAIL ctl at %0t got addr=%0d fs=%b ack=%b disp=%b need addr=%0d fs=%b ack=%b disp=%b",
                          $time, addr, frame_start, swap_ack, disp_buf, mc.addr, mc.fs, mc.ack, mc.disp);
         end
      end
   end

   initial begin
      rst_n = 1'b1; hcount = '0; vcount = '0; hsync = 1'b1; vsync = 1'b1;
      blank = 1'b1; swap_req = 1'b0; flood = 1'b0; grid = 1'b0;
      want_flood = 0; want_grid = 0;
      for (int i = 0; i < 8192; i++) begin
         mem1[i] = 30'($urandom);
         mem2[i] = 30'($urandom);
      end
      mem1[524] = {1'b1, 3'd0, 12'hF80, 14'h0};
      do_reset(3);

      // Decode of a known tile: person, then food
      drive(100, 37, 1'b1, 1'b1, 1'b0);
      drive(101, 37, 1'b0, 1'b1, 1'b0);
      pad(5);
      mem1[524] = {1'b1, 3'd1, 12'hF80, 14'h0};
      drive(100, 37, 1'b1, 1'b0, 1'b0);
      pad(5);

      // Flood latched at the next frame boundary, then an empty tile
      want_flood = 1;
      frame(80, 0);
      mem1[524] = {1'b0, 3'd0, 12'hF80, 14'h0};
      drive(100, 37, 1'b1, 1'b1, 1'b0);
      pad(5);
      want_flood = 0;

      frame(100, 3);
      frame(100, 0);
      frame(100, 2);
      frame(100, 1);
      frame(100, 1);

      for (int f = 0; f < 5; f++) begin
         want_flood = 1'($urandom_range(0, 1));
         want_grid  = (f != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         frame(150, $urandom_range(0, 3));
      end

      // Reset mid-frame after a swap has landed
      want_grid = 0;
      frame(60, 3);
      repeat (20) drive($urandom_range(0, 1023), 300, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'b1);
      do_reset(4);
      frame(100, 0);
      pad(8);
      @(posedge clk);
      #2;
      mon_en = 0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
